// File: rtl/uart_cmd_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_cmd_pkg                                                               |
// | Shared states, ASCII constants and byte classifiers for the command parser |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    VAL0 = 3'd2,
    VAL1 = 3'd3,
    TERM = 3'd4
  } cmd_state_t;

  localparam logic [7:0] CHR_START = 8'h23;  // '#'
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_T_MAX = 8'h54;  // 'T'
  localparam logic [7:0] CHR_T_MIN = 8'h74;  // 't'
  localparam logic [7:0] CHR_H_MAX = 8'h48;  // 'H'
  localparam logic [7:0] CHR_H_MIN = 8'h68;  // 'h'

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CHR_T_MAX) || (b == CHR_T_MIN) ||
           (b == CHR_H_MAX) || (b == CHR_H_MIN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_timer.sv
// +----------------------------------------------------------------------------+
// | uart_cmd_timer                                                             |
// | Inter-byte gap counter; pulses o_expire when the gap reaches the limit     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_count;

  // A clear in the same cycle masks the expiry: an arriving byte wins.
  assign o_expire = i_enable && !i_clear && (r_count == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// +----------------------------------------------------------------------------+
// | uart_cmd_parser                                                            |
// | Extracts "#<cmd><d1><d0><CR|LF>" frames from the UART byte stream.         |
// | Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] chr_cmd,
  output logic [7:0] chr_val0,
  output logic [7:0] chr_val1,
  output logic       rx_msg_done,
  output logic       frame_err
);

  cmd_state_t r_state;
  logic [7:0] r_sh_cmd, r_sh_val0, r_sh_val1;
  logic [7:0] r_cmd, r_val0, r_val1;
  logic       r_msg_done, r_frame_err;
  logic       w_expire;

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (rx_valid || (r_state == IDLE)),
    .i_enable (r_state != IDLE),
    .o_expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_expire         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sh_cmd    <= 8'h00;
      r_sh_val0   <= 8'h00;
      r_sh_val1   <= 8'h00;
      r_cmd       <= 8'h00;
      r_val0      <= 8'h00;
      r_val1      <= 8'h00;
      r_msg_done  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_msg_done  <= 1'b0;
      r_frame_err <= 1'b0;
      if (rx_valid) begin
        if ((rx_byte == CHR_START) && (r_state != IDLE)) begin
          // Start marker inside a frame: report it and resynchronise.
          r_frame_err <= 1'b1;
          r_sh_cmd    <= 8'h00;
          r_sh_val0   <= 8'h00;
          r_sh_val1   <= 8'h00;
          r_state     <= CMD;
        end else begin
          case (r_state)
            IDLE: begin
              if (rx_byte == CHR_START) r_state <= CMD;
            end
            CMD: begin
              if (is_cmd(rx_byte)) begin
                r_sh_cmd <= rx_byte;
                r_state  <= VAL0;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= IDLE;
              end
            end
            VAL0: begin
              if (is_digit(rx_byte)) begin
                r_sh_val0 <= rx_byte;
                r_state   <= VAL1;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= IDLE;
              end
            end
            VAL1: begin
              if (is_digit(rx_byte)) begin
                r_sh_val1 <= rx_byte;
                r_state   <= TERM;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= IDLE;
              end
            end
            TERM: begin
              if ((rx_byte == CHR_CR) || (rx_byte == CHR_LF)) begin
                r_cmd      <= r_sh_cmd;
                r_val0     <= r_sh_val0;
                r_val1     <= r_sh_val1;
                r_msg_done <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
              r_state <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end else if (w_expire) begin
        r_frame_err <= 1'b1;
        r_state     <= IDLE;
      end
    end
  end

  assign chr_cmd     = r_cmd;
  assign chr_val0    = r_val0;
  assign chr_val1    = r_val1;
  assign rx_msg_done = r_msg_done;
  assign frame_err   = r_frame_err;

endmodule

`default_nettype wire
